// File: rtl/pwm_multichannel.sv
// N-channel PWM: one shared prescaled period counter, double-buffered per-channel duty.
// Latency: pwm_out/period_end are registered, 1 clk after cnt/en; no backpressure (writes always accepted).
module pwm_multichannel #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int PRESC_DIV   = 1,
  parameter bit ACTIVE_HIGH = 1'b1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PRESC_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] period,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [N_CH-1:0]  en,
  output logic [N_CH-1:0]  pwm_out,
  output logic             period_end
);

  localparam logic [N_CH-1:0] IDLE = ACTIVE_HIGH ? '0 : '1;

  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   p_act;
  logic [CNT_W-1:0]   shadow   [N_CH];
  logic [CNT_W-1:0]   duty_act [N_CH];
  logic               tick;
  logic               p_zero;
  logic               boundary;
  logic               wr_ok;
  logic [N_CH-1:0]    raw;

  assign tick     = (presc == PRESC_W'(PRESC_DIV - 1));
  assign p_zero   = (p_act == '0);
  // A zero period keeps the counter parked and reloads on every tick, so reset self-starts.
  assign boundary = tick && (p_zero || (cnt == p_act - CNT_W'(1)));
  assign wr_ok    = wr_en && (32'(wr_ch) < N_CH);

  always_comb begin
    raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      raw[i] = en[i] && !p_zero && (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      cnt        <= '0;
      p_act      <= '0;
      period_end <= 1'b0;
      pwm_out    <= IDLE;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i]   <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      presc <= tick ? '0 : presc + PRESC_W'(1);

      if (boundary) begin
        cnt   <= '0;
        p_act <= period;
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end

      // duty_act takes the pre-write shadow, so a write on the boundary edge waits a full period.
      for (int i = 0; i < N_CH; i++) begin
        if (boundary) duty_act[i] <= shadow[i];
      end
      if (wr_ok) shadow[wr_ch] <= wr_duty;

      pwm_out    <= ACTIVE_HIGH ? raw : ~raw;
      period_end <= boundary && !p_zero;
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: four instances (prescaler 1/4, both polarities, 5 channels)
// checked every cycle against a clock-phase reference model plus directed window measurements.
`timescale 1ns/1ps
module tb_pwm_multichannel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] period;
  logic [7:0] wr_duty;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [4:0] en;
  logic       wr_en4;
  logic [3:0] pwm0, pwm1, pwm2;
  logic [4:0] pwm3;
  logic       pe0, pe1, pe2, pe3;

  // 4-channel instances only see in-range channel numbers on their 2-bit port
  assign wr_en4 = wr_en && (wr_ch < 3'd4);

  pwm_multichannel #(.N_CH(4), .CNT_W(8), .PRESC_DIV(1), .ACTIVE_HIGH(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .period(period), .wr_en(wr_en4), .wr_ch(wr_ch[1:0]),
    .wr_duty(wr_duty), .en(en[3:0]), .pwm_out(pwm0), .period_end(pe0));
  pwm_multichannel #(.N_CH(4), .CNT_W(8), .PRESC_DIV(4), .ACTIVE_HIGH(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .period(period), .wr_en(wr_en4), .wr_ch(wr_ch[1:0]),
    .wr_duty(wr_duty), .en(en[3:0]), .pwm_out(pwm1), .period_end(pe1));
  pwm_multichannel #(.N_CH(4), .CNT_W(8), .PRESC_DIV(4), .ACTIVE_HIGH(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .period(period), .wr_en(wr_en4), .wr_ch(wr_ch[1:0]),
    .wr_duty(wr_duty), .en(en[3:0]), .pwm_out(pwm2), .period_end(pe2));
  pwm_multichannel #(.N_CH(5), .CNT_W(8), .PRESC_DIV(1), .ACTIVE_HIGH(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .period(period), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .en(en), .pwm_out(pwm3), .period_end(pe3));

  logic [4:0] pwm_s [4];
  logic       pe_s  [4];
  assign pwm_s[0] = {1'b0, pwm0};
  assign pwm_s[1] = {1'b0, pwm1};
  assign pwm_s[2] = {1'b0, pwm2};
  assign pwm_s[3] = pwm3;
  assign pe_s[0]  = pe0;
  assign pe_s[1]  = pe1;
  assign pe_s[2]  = pe2;
  assign pe_s[3]  = pe3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time measured in clk cycles since the current period began.
  int         pd_of  [4] = '{1, 4, 4, 1};
  bit         ah_of  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  int         nch_of [4] = '{4, 4, 4, 5};
  int         phase  [4];
  int         p_m    [4];
  int         sh     [4][5];
  int         act    [4][5];
  logic [4:0] exp_pwm [4];
  logic       exp_pe  [4];
  bit         started = 1'b0;

  function automatic void model_step(input int k);
    int         tk;
    int         len;
    logic [4:0] r;
    logic [4:0] msk;
    msk = 5'((1 << nch_of[k]) - 1);
    if (!rst_n) begin
      phase[k] = 0;
      p_m[k]   = 0;
      for (int c = 0; c < 5; c++) begin
        sh[k][c]  = 0;
        act[k][c] = 0;
      end
      exp_pe[k]  = 1'b0;
      exp_pwm[k] = ah_of[k] ? 5'd0 : msk;
    end else begin
      tk = phase[k] / pd_of[k];
      r  = '0;
      for (int c = 0; c < nch_of[k]; c++)
        r[c] = en[c] && (p_m[k] != 0) && (tk < act[k][c]);
      exp_pwm[k] = ah_of[k] ? r : (~r & msk);
      len = ((p_m[k] == 0) ? 1 : p_m[k]) * pd_of[k];
      exp_pe[k] = (phase[k] == len - 1) && (p_m[k] != 0);
      if (phase[k] == len - 1) begin
        phase[k] = 0;
        p_m[k]   = int'(period);
        for (int c = 0; c < 5; c++) act[k][c] = sh[k][c];
      end else begin
        phase[k]++;
      end
      if (wr_en && (int'(wr_ch) < nch_of[k])) sh[k][wr_ch] = int'(wr_duty);
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) model_step(k);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("model_pwm%0d", k), 32'(pwm_s[k]), 32'(exp_pwm[k]));
        check($sformatf("model_pe%0d", k), 32'(pe_s[k]), 32'(exp_pe[k]));
      end
    end
  end

  task automatic rand_inputs();
    period  = 8'($urandom_range(0, 12));
    wr_en   = 1'($urandom_range(0, 1));
    wr_ch   = 3'($urandom_range(0, 7));
    wr_duty = 8'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write(input logic [2:0] ch, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = ch; wr_duty = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pe(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pe_s[k] && n < 1000);
    if (!pe_s[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pe%0d: no period_end within 1000 clk", k);
    end
  endtask

  // Measures one period window starting at a period_end cycle; optional write at offset wj.
  task automatic win(input int k, input int ch, input int wj, input logic [2:0] wc,
                     input logic [7:0] wd, output int hi, output int len, output int mism);
    hi = 0; len = 0; mism = 0;
    do begin
      hi += int'(pwm_s[k][ch]);
      if (pwm2 !== ~pwm1) mism++;
      if (len == wj) begin
        wr_en = 1'b1; wr_ch = wc; wr_duty = wd;
      end else begin
        wr_en = 1'b0;
      end
      len++;
      @(negedge clk);
    end while (!pe_s[k] && len < 2000);
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] period;
    int         ch;
    logic [7:0] duty;
    int         hi0, len0, hi1, len1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int hi, len, mism, cntnz;
    tbl[0] = '{8'd10, 0, 8'd3,   3,  10, 12, 40};
    tbl[1] = '{8'd10, 1, 8'd0,   0,  10, 0,  40};
    tbl[2] = '{8'd10, 2, 8'd10,  10, 10, 40, 40};
    tbl[3] = '{8'd10, 3, 8'd255, 10, 10, 40, 40};
    tbl[4] = '{8'd5,  1, 8'd2,   2,  5,  8,  20};
    tbl[5] = '{8'd1,  0, 8'd1,   1,  1,  4,  4};
    tbl[6] = '{8'd7,  2, 8'd6,   6,  7,  24, 28};

    rst_n = 1'b0; period = '0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; en = '0;

    // Reset held with random inputs: outputs idle throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pwm0", 32'(pwm0), 32'h0);
      check("rst_pwm2", 32'(pwm2), 32'hF);
      check("rst_pe0", 32'(pe0), 32'h0);
      rand_inputs();
      en = 5'($urandom_range(0, 31));
      rst_n = 1'b0;
    end
    wr_en = 1'b0;

    // Steady-state high time and period length per table row
    foreach (tbl[v]) begin
      do_reset();
      en = 5'h1F;
      period = tbl[v].period;
      write(3'(tbl[v].ch), tbl[v].duty);
      for (int k = 0; k < 2; k++) begin
        wait_pe(k);
        wait_pe(k);
        win(k, tbl[v].ch, -1, 3'd0, 8'd0, hi, len, mism);
        check($sformatf("tbl%0d_hi%0d", v, k), 32'(hi), 32'(k == 0 ? tbl[v].hi0 : tbl[v].hi1));
        check($sformatf("tbl%0d_len%0d", v, k), 32'(len), 32'(k == 0 ? tbl[v].len0 : tbl[v].len1));
        if (k == 1) check($sformatf("tbl%0d_polarity", v), 32'(mism), 32'd0);
      end
    end

    // Out-of-range channel writes are dropped (5-channel instance)
    do_reset();
    en = 5'h1F; period = 8'd10;
    write(3'd1, 8'd6);
    write(3'd4, 8'd4);
    write(3'd5, 8'd0);
    write(3'd7, 8'd0);
    wait_pe(3);
    wait_pe(3);
    win(3, 1, -1, 3'd0, 8'd0, hi, len, mism);
    check("oor_ch1_hi", 32'(hi), 32'd6);
    wait_pe(3);
    win(3, 4, -1, 3'd0, 8'd0, hi, len, mism);
    check("oor_ch4_hi", 32'(hi), 32'd4);

    // Mid-period write lands next period; boundary-cycle write lands one period later
    do_reset();
    en = 5'h1F; period = 8'd10;
    write(3'd1, 8'd5);
    wait_pe(0);
    wait_pe(0);
    win(0, 1, 2, 3'd1, 8'd7, hi, len, mism);
    check("dbuf_cur_hi", 32'(hi), 32'd5);
    check("dbuf_cur_len", 32'(len), 32'd10);
    win(0, 1, 9, 3'd1, 8'd2, hi, len, mism);
    check("dbuf_next_hi", 32'(hi), 32'd7);
    win(0, 1, -1, 3'd0, 8'd0, hi, len, mism);
    check("dbuf_bnd_hold_hi", 32'(hi), 32'd7);
    win(0, 1, -1, 3'd0, 8'd0, hi, len, mism);
    check("dbuf_bnd_new_hi", 32'(hi), 32'd2);

    // One-cycle reset at cnt=6 aborts the period; outputs stay idle afterwards
    do_reset();
    en = 5'h1F; period = 8'd10;
    write(3'd0, 8'd3);
    write(3'd2, 8'd10);
    wait_pe(0);
    wait_pe(0);
    repeat (6) @(negedge clk);
    check("pre_rst_pwm0", 32'(pwm0), 32'h4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_pwm0", 32'(pwm0), 32'h0);
    check("mid_rst_pe0", 32'(pe0), 32'h0);
    cntnz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm0 != 4'h0) cntnz++;
    end
    check("post_rst_idle", 32'(cntnz), 32'd0);

    // Random traffic, checked cycle-by-cycle by the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rand_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) en = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
